// File: rtl/pht_access_scheduler_pkg.sv
// Shared types and helpers for the PHT access scheduler.
// Holds the scheduler state enum, counter constants and saturating update.
package pht_access_scheduler_pkg;

  localparam int DEF_IDX_W = 12;

  localparam logic [1:0] SAT_TAKEN = 2'b11;
  localparam logic [1:0] SAT_NT    = 2'b00;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RMW_WR = 2'd2
  } sched_state_e;

  function automatic logic [1:0] sat_upd(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != SAT_TAKEN) res = cnt + 2'b01;
    end else begin
      if (cnt != SAT_NT) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Pending resolved-branch update queue of {index, taken} entries.
// Ports: clk_i/rst_ni, clear_i, push_i + entry, pop_i, head_*_o, full_o, empty_o.
module pht_update_fifo
  import pht_access_scheduler_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [IDX_W-1:0] push_idx_i,
  input  logic             push_taken_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_taken_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [IDX_W:0] ent_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;
  logic           do_push, do_pop;

  // Extra pointer bit tells full from empty when the low bits match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_idx_o   = ent_q[rd_q[AW-1:0]][IDX_W:1];
  assign head_taken_o = ent_q[rd_q[AW-1:0]][0];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push && !clear_i)
        ent_q[wr_q[AW-1:0]] <= {push_idx_i, push_taken_i};
    end
  end

endmodule

// File: rtl/pht_access_scheduler.sv
// Single-port PHT owner: init sweep, lookup/update arbitration, GHR.
// Ports: CLK/RESET/FLUSH, lookup_*, pred_*, resolve_*, ghr, init_done,
// pht_* RAM side, stat_* counters (built only with PHT_SCHED_STATS_EN).
module pht_access_scheduler
  import pht_access_scheduler_pkg::*;
#(
  parameter int         IDX_W      = DEF_IDX_W,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_index,
  input  logic             resolve_taken,
  output logic             resolve_ready,
  output logic [IDX_W-1:0] ghr,
  output logic             init_done,
  output logic [IDX_W-1:0] pht_addr,
  output logic             pht_we,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_stalls
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic             pv_q;

  logic             f_full, f_empty;
  logic [IDX_W-1:0] h_idx;
  logic             h_tk;
  logic             push, pop, upd_rd, flush_act;

  assign init_done     = (state_q != INIT);
  assign flush_act     = FLUSH && (state_q != INIT);
  assign resolve_ready = init_done && !f_full;
  assign push          = resolve_valid && resolve_ready && !FLUSH;
  assign ghr           = ghr_q;
  assign pred_valid    = pv_q;
  assign pred_taken    = pv_q & pht_rdata[1];

  pht_update_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (CLK),
    .rst_ni       (RESET),
    .clear_i      (flush_act),
    .push_i       (push),
    .push_idx_i   (resolve_index),
    .push_taken_i (resolve_taken),
    .pop_i        (pop),
    .head_idx_o   (h_idx),
    .head_taken_o (h_tk),
    .full_o       (f_full),
    .empty_o      (f_empty)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pht_addr     = '0;
    pht_we       = 1'b0;
    pht_wdata    = '0;
    lookup_ready = 1'b0;
    upd_rd       = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      INIT: begin
        pht_we    = 1'b1;
        pht_addr  = ptr_q;
        pht_wdata = INIT_VAL;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (!FLUSH) begin
          // A full queue must drain before fetch can be served again.
          if (f_full)            upd_rd       = 1'b1;
          else if (lookup_valid) lookup_ready = 1'b1;
          else if (!f_empty)     upd_rd       = 1'b1;
          if (upd_rd) begin
            pht_addr = h_idx;
            state_d  = RMW_WR;
          end else if (lookup_ready) begin
            pht_addr = lookup_index;
          end
        end
      end
      RMW_WR: begin
        state_d = IDLE;
        if (!FLUSH) begin
          pht_we    = 1'b1;
          pht_addr  = h_idx;
          pht_wdata = sat_upd(pht_rdata, h_tk);
          pop       = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
    // RAM controls must go quiet the instant reset asserts.
    if (!RESET) begin
      pht_we    = 1'b0;
      pht_addr  = '0;
      pht_wdata = '0;
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (flush_act) ghr_d = '0;
    else if (push) ghr_d = {ghr_q[IDX_W-2:0], resolve_taken};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      pv_q    <= lookup_ready;
    end
  end

`ifdef PHT_SCHED_STATS_EN
  logic [31:0] lk_q, up_q, st_q;
  logic        stall;

  assign stall = lookup_valid && !lookup_ready && init_done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lk_q <= '0;
      up_q <= '0;
      st_q <= '0;
    end else begin
      if (lookup_ready) lk_q <= lk_q + 32'd1;
      if (pop)          up_q <= up_q + 32'd1;
      if (stall)        st_q <= st_q + 32'd1;
    end
  end

  assign stat_lookups = lk_q;
  assign stat_updates = up_q;
  assign stat_stalls  = st_q;
`else
  assign stat_lookups = '0;
  assign stat_updates = '0;
  assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Directed bench for pht_access_scheduler with a behavioural sync-read PHT RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pht_access_scheduler;

  localparam int IDX_W = 12;
`ifdef PHT_SCHED_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic             CLK, RESET, FLUSH;
  logic             lookup_valid, lookup_ready;
  logic [IDX_W-1:0] lookup_index;
  logic             pred_valid, pred_taken;
  logic             resolve_valid, resolve_taken, resolve_ready;
  logic [IDX_W-1:0] resolve_index, ghr, pht_addr;
  logic             init_done, pht_we;
  logic [1:0]       pht_wdata, pht_rdata;
  logic [31:0]      stat_lookups, stat_updates, stat_stalls;

  logic [1:0] ram [1 << IDX_W];

  int n_chk  = 0;
  int n_pass = 0;
  int bad    = 0;

  pht_access_scheduler dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .FLUSH         (FLUSH),
    .lookup_valid  (lookup_valid),
    .lookup_index  (lookup_index),
    .lookup_ready  (lookup_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_index (resolve_index),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .ghr           (ghr),
    .init_done     (init_done),
    .pht_addr      (pht_addr),
    .pht_we        (pht_we),
    .pht_wdata     (pht_wdata),
    .pht_rdata     (pht_rdata),
    .stat_lookups  (stat_lookups),
    .stat_updates  (stat_updates),
    .stat_stalls   (stat_stalls)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pht_we) ram[pht_addr] <= pht_wdata;
    pht_rdata <= ram[pht_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic resolve(input logic [IDX_W-1:0] idx, input logic tk);
    @(negedge CLK);
    resolve_valid = 1'b1;
    resolve_index = idx;
    resolve_taken = tk;
    @(negedge CLK);
    resolve_valid = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ghr"}, 32'(ghr), 0);
    chk({tag, "_pv"}, 32'(pred_valid), 0);
    chk({tag, "_pt"}, 32'(pred_taken), 0);
    chk({tag, "_lr"}, 32'(lookup_ready), 0);
    chk({tag, "_rr"}, 32'(resolve_ready), 0);
    chk({tag, "_idone"}, 32'(init_done), 0);
    chk({tag, "_we"}, 32'(pht_we), 0);
    chk({tag, "_addr"}, 32'(pht_addr), 0);
    chk({tag, "_wdata"}, 32'(pht_wdata), 0);
    chk({tag, "_slk"}, stat_lookups, 0);
    chk({tag, "_sup"}, stat_updates, 0);
    chk({tag, "_sst"}, stat_stalls, 0);
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0;
    lookup_valid = 1'b0; lookup_index = '0;
    resolve_valid = 1'b0; resolve_index = '0; resolve_taken = 1'b0;
    #2 RESET = 1'b0;
    #1 chk_reset_vals("rst");

    // Init sweep: one write of INIT_VAL per cycle, addresses 0..4095.
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      #1;
      if (!(pht_we === 1'b1 && pht_addr === 12'(i) &&
            pht_wdata === 2'b01 && init_done === 1'b0 &&
            resolve_ready === 1'b0))
        bad++;
      @(negedge CLK);
    end
    chk("sweep_bad_cycles", 32'(bad), 0);
    #1;
    chk("idone", 32'(init_done), 1);
    chk("idle_we", 32'(pht_we), 0);
    chk("idle_rr", 32'(resolve_ready), 1);
    chk("ram_last", 32'(ram[12'hFFF]), 1);

    // First lookup after the sweep.
    lookup_valid = 1'b1;
    lookup_index = 12'h123;
    #1;
    chk("lk_ready", 32'(lookup_ready), 1);
    chk("lk_addr", 32'(pht_addr), 32'h123);
    chk("lk_we", 32'(pht_we), 0);
    @(negedge CLK);
    lookup_valid = 1'b0;
    #1;
    chk("lk_pv", 32'(pred_valid), 1);
    chk("lk_pt", 32'(pred_taken), 0);
    @(negedge CLK);
    #1 chk("lk_pv_drop", 32'(pred_valid), 0);

    // Saturating increment 01 -> 10 -> 11 -> 11.
    resolve(12'h010, 1'b1);
    chk("inc1", 32'(ram[12'h010]), 2);
    resolve(12'h010, 1'b1);
    chk("inc2", 32'(ram[12'h010]), 3);
    resolve(12'h010, 1'b1);
    chk("inc_sat", 32'(ram[12'h010]), 3);
    chk("ghr_007", 32'(ghr), 32'h007);

    // Saturating decrement 01 -> 00 -> 00.
    resolve(12'h020, 1'b0);
    chk("dec1", 32'(ram[12'h020]), 0);
    resolve(12'h020, 1'b0);
    chk("dec_sat", 32'(ram[12'h020]), 0);
    resolve(12'h020, 1'b0);
    chk("dec_sat2", 32'(ram[12'h020]), 0);
    chk("ghr_038", 32'(ghr), 32'h038);

    // Fill the queue while fetch keeps requesting.
    @(negedge CLK);
    lookup_valid = 1'b1;
    lookup_index = 12'h200;
    for (int k = 0; k < 4; k++) begin
      resolve_valid = 1'b1;
      resolve_index = 12'h040 + 12'(k);
      resolve_taken = 1'b1;
      #1;
      chk($sformatf("fill_lr%0d", k), 32'(lookup_ready), 1);
      chk($sformatf("fill_rr%0d", k), 32'(resolve_ready), 1);
      @(negedge CLK);
    end
    resolve_valid = 1'b0;
    #1;
    chk("full_rr", 32'(resolve_ready), 0);
    chk("full_lr", 32'(lookup_ready), 0);
    chk("full_we", 32'(pht_we), 0);
    chk("full_addr", 32'(pht_addr), 32'h040);
    @(negedge CLK);
    #1;
    chk("rmw_lr", 32'(lookup_ready), 0);
    chk("rmw_we", 32'(pht_we), 1);
    chk("rmw_addr", 32'(pht_addr), 32'h040);
    chk("rmw_wdata", 32'(pht_wdata), 2);
    @(negedge CLK);
    #1;
    chk("after_lr", 32'(lookup_ready), 1);
    chk("after_rr", 32'(resolve_ready), 1);
    @(negedge CLK);
    lookup_valid = 1'b0;
    #1;
    chk("st_lookups", stat_lookups, ST ? 32'd6 : 32'd0);
    chk("st_stalls", stat_stalls, ST ? 32'd2 : 32'd0);
    chk("st_updates", stat_updates, ST ? 32'd7 : 32'd0);
    chk("ghr_38f", 32'(ghr), 32'h38F);
    repeat (8) @(negedge CLK);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain%0d", k), 32'(ram[12'h040 + 12'(k)]), 2);
    chk("st_updates2", stat_updates, ST ? 32'd10 : 32'd0);

    // Flush during the write half of an update.
    @(negedge CLK);
    resolve_valid = 1'b1;
    resolve_index = 12'h030;
    resolve_taken = 1'b1;
    @(negedge CLK);
    resolve_index = 12'h031;
    #1;
    chk("fl_rd_addr", 32'(pht_addr), 32'h030);
    @(negedge CLK);
    resolve_valid = 1'b0;
    FLUSH = 1'b1;
    #1 chk("fl_we", 32'(pht_we), 0);
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    chk("fl_pv", 32'(pred_valid), 0);
    chk("fl_ghr", 32'(ghr), 0);
    chk("fl_rr", 32'(resolve_ready), 1);
    chk("fl_we_idle", 32'(pht_we), 0);
    repeat (4) @(negedge CLK);
    chk("fl_ram30", 32'(ram[12'h030]), 1);
    chk("fl_ram31", 32'(ram[12'h031]), 1);

    // Asynchronous reset in the middle of a read-modify-write.
    resolve_valid = 1'b1;
    resolve_index = 12'h050;
    resolve_taken = 1'b1;
    @(negedge CLK);
    resolve_valid = 1'b0;
    @(negedge CLK);
    #1 chk("mid_we", 32'(pht_we), 1);
    #1 RESET = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge CLK);
    chk("arst_ram50", 32'(ram[12'h050]), 1);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("resweep_addr%0d", i), 32'(pht_addr), 32'(i));
      chk($sformatf("resweep_we%0d", i), 32'(pht_we), 1);
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pht_access_scheduler.md
Name: pht_access_scheduler

Overview:
- Owns the single-ported 2-bit-counter pattern history table (PHT) RAM of the global branch predictor.
- Arbitrates each cycle between fetch-stage prediction lookups and resolved-branch counter updates.
- Updates are buffered in a small FIFO and applied as read-modify-write sequences.
- Also owns the global history register (GHR) and sweeps the table to a known value after reset.

Parameters:
- IDX_W, 12, PHT index width; table depth is 2**IDX_W.
- FIFO_DEPTH, 4, number of pending resolved-branch updates (power of 2, >= 2).
- INIT_VAL, 2'b01, counter value written to every entry during the init sweep (weakly not-taken).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous pipeline flush.
- lookup_valid  in  1  fetch requests a prediction.
- lookup_index  in  IDX_W  PHT index for the lookup (GHR-derived by fetch).
- lookup_ready  out  1  lookup accepted this cycle.
- pred_valid  out  1  prediction valid.
- pred_taken  out  1  prediction, equal to counter bit 1.
- resolve_valid  in  1  a branch has resolved.
- resolve_index  in  IDX_W  index used when that branch was predicted.
- resolve_taken  in  1  actual outcome.
- resolve_ready  out  1  update accepted (equals FIFO not full and init done).
- ghr  out  IDX_W  global history register.
- init_done  out  1  init sweep complete.
- pht_addr  out  IDX_W  RAM address.
- pht_we  out  1  RAM write enable.
- pht_wdata  out  2  RAM write data.
- pht_rdata  in  2  RAM read data; synchronous, valid the cycle after a read is issued.
- stat_lookups  out  32  lookup count (optional feature).
- stat_updates  out  32  update count (optional feature).
- stat_stalls  out  32  lookup stall count (optional feature).

Behaviour:
- Reset values:
  - ghr=0, pred_valid=0, pred_taken=0.
  - lookup_ready=0, resolve_ready=0, init_done=0.
  - pht_we=0, pht_addr=0, pht_wdata=0.
  - FIFO empty; state=INIT; init pointer=0.
  - All stat counters=0.
- INIT state:
  - Each cycle: pht_we=1, pht_addr=init pointer, pht_wdata=INIT_VAL, then pointer increments.
  - After writing entry 2**IDX_W-1, go to IDLE and set init_done=1.
  - Sweep takes exactly 2**IDX_W cycles after RESET deasserts.
  - lookup_ready and resolve_ready are held at 0 throughout.
- Grant priority, one RAM op per cycle, evaluated in IDLE:
  - (1) If the FIFO is full, issue an update read.
  - (2) Otherwise, if lookup_valid, grant the lookup.
  - (3) Otherwise, if the FIFO is non-empty, issue an update read.
- Lookup handshake:
  - lookup_ready is combinational and equals the grant.
  - Accepted at cycle N: pht_addr=lookup_index, pht_we=0.
  - At N+1: pred_valid=1 and pred_taken=pht_rdata[1]. pred_valid is 0 in cycles with no accepted lookup.
- Update read-modify-write:
  - Cycle A (IDLE -> RMW_WR): read the FIFO head's index.
  - Cycle A+1 (RMW_WR -> IDLE): write the saturating counter, then pop the FIFO.
    - If taken: 11 stays 11, otherwise +1.
    - If not taken: 00 stays 00, otherwise -1.
  - lookup_ready=0 in RMW_WR.
  - Back-to-back updates: IDLE, RMW_WR, IDLE, RMW_WR. At most one update completes every 2 cycles.
- Resolve push and GHR:
  - A push happens when resolve_valid and resolve_ready are both high.
  - On push, ghr <= {ghr[IDX_W-2:0], resolve_taken}.
  - resolve_ready does not depend on a same-cycle pop; a full FIFO refuses the push even when popping.
- FLUSH, synchronous, any state except INIT:
  - Clears the FIFO, ghr and pred_valid.
  - An in-flight RMW_WR is abandoned: pht_we=0 that cycle, return to IDLE.
  - Lookup and resolve inputs are ignored in the FLUSH cycle.
  - The table is not re-initialised.
  - FLUSH during INIT is ignored.
- RESET asserted mid-RMW: no write completes; the INIT sweep restarts from entry 0.
- Lookup index equal to a queued update index: the lookup reads the current RAM value (stale by design, no forwarding).

Optional Feature:
- Macro: PHT_SCHED_STATS_EN.
- When defined:
  - stat_lookups increments on each accepted lookup.
  - stat_updates increments on each RMW write.
  - stat_stalls increments each cycle lookup_valid=1 and lookup_ready=0 after init_done.
  - All three counters wrap at 2**32 and are cleared only by RESET.
- When undefined: the stat ports still exist, are tied to 0, and no counter flops are built.

Decomposition:
- Shared package holds:
  - state enum {INIT, IDLE, RMW_WR};
  - the counter constants SAT_TAKEN=2'b11 and SAT_NT=2'b00;
  - a function for the 2-bit saturating increment/decrement;
  - the default IDX_W.
- One sub-module: pht_update_fifo, a synchronous FIFO with {index, taken} entries, full/empty flags, push/pop/clear.

Test Plan:
- Reset release -> exactly 4096 write cycles of INIT_VAL to addresses 0..4095; then init_done=1, and a lookup of idx 0x123 gives pred_valid=1, pred_taken=0 one cycle later.
- Three resolves (idx 0x010, taken=1) with no lookups -> entry 0x010 reads 01->10->11->11 across the RMW writes, and ghr ends at 0x007.
- Resolve idx 0x020 with taken=0 twice from 01 -> 00, then 00 held; no underflow.
- Fill the FIFO with 4 updates while lookup_valid is held high -> resolve_ready=0, the update read wins over the lookup, lookup_ready=0 in that cycle and in RMW_WR, and stat_stalls counts those cycles (stats build).
- FLUSH asserted in the RMW_WR cycle for idx 0x030 -> no write (entry stays 01), FIFO empty, ghr=0, pred_valid=0 the next cycle.
- RESET asserted during an RMW sequence -> all outputs take their reset values asynchronously, and the INIT sweep restarts at address 0.
